// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Multi-port integer register file for the dual-issue issue stage, with
//   per-byte write enables and a per-register busy scoreboard.
//   Register 0 is hardwired zero and is never busy.
//
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     raddr/rdata/rbusy NR_READ combinational read ports (data + busy bit)
//     we/waddr/wdata    NR_WRITE write ports, per-byte enables
//     wclr              writeback done on write port j: clear busy[waddr[j]]
//     issue_valid/dst   NR_ISSUE busy-set ports
//     flush             clear every busy bit (issue ignored that cycle)
//     busy_vec          registered scoreboard
//
//   Optional feature (macro REGFILE_BYPASS_EN): read ports forward same-cycle
//   write data byte-wise and report a register as not busy when a same-cycle
//   writeback clears it (and no same-cycle issue re-claims it).
module regfile_scoreboard #(
   parameter int REG_NUM  = 64,
   parameter int DATA_W   = 32,
   parameter int NR_READ  = 4,
   parameter int NR_WRITE = 2,
   parameter int NR_ISSUE = 2,
   parameter int AW       = $clog2(REG_NUM)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NR_READ*AW-1:0]        raddr,
   output logic [NR_READ*DATA_W-1:0]    rdata,
   output logic [NR_READ-1:0]           rbusy,
   input  logic [NR_WRITE*(DATA_W/8)-1:0] we,
   input  logic [NR_WRITE*AW-1:0]       waddr,
   input  logic [NR_WRITE*DATA_W-1:0]   wdata,
   input  logic [NR_WRITE-1:0]          wclr,
   input  logic [NR_ISSUE-1:0]          issue_valid,
   input  logic [NR_ISSUE*AW-1:0]       issue_dst,
   input  logic                         flush,
   output logic [REG_NUM-1:0]           busy_vec
);

   localparam int NB = DATA_W / 8;

   logic [REG_NUM-1:0][DATA_W-1:0] regs;
   logic [REG_NUM-1:0]             busy;
   logic [REG_NUM-1:0]             busy_nxt;

   // Ports are visited in ascending order, so on a byte collision the last
   // (highest-index) non-blocking assignment is the one that sticks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs <= '0;
      end else begin
         for (int j = 0; j < NR_WRITE; j++) begin
            for (int b = 0; b < NB; b++) begin
               if (we[j*NB+b] && (waddr[j*AW +: AW] != '0))
                  regs[waddr[j*AW +: AW]][b*8 +: 8] <= wdata[j*DATA_W + b*8 +: 8];
            end
         end
      end
   end

   // Clears are applied first, then sets, so a same-cycle issue overrides a
   // writeback clear on the same register (new producer supersedes old one).
   always_comb begin
      busy_nxt = busy;
      if (flush) begin
         busy_nxt = '0;
      end else begin
         for (int j = 0; j < NR_WRITE; j++)
            if (wclr[j]) busy_nxt[waddr[j*AW +: AW]] = 1'b0;
         for (int k = 0; k < NR_ISSUE; k++)
            if (issue_valid[k]) busy_nxt[issue_dst[k*AW +: AW]] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

   assign busy_vec = busy;

   for (genvar i = 0; i < NR_READ; i++) begin : g_rd
      logic [AW-1:0]     ra;
      logic [DATA_W-1:0] rd;
      logic              bz;

      assign ra = raddr[i*AW +: AW];

`ifdef REGFILE_BYPASS_EN
      logic clr_hit;
      logic iss_hit;

      always_comb begin
         rd      = regs[ra];
         bz      = busy[ra];
         clr_hit = 1'b0;
         iss_hit = 1'b0;
         for (int j = 0; j < NR_WRITE; j++) begin
            for (int b = 0; b < NB; b++)
               if (we[j*NB+b] && (waddr[j*AW +: AW] == ra))
                  rd[b*8 +: 8] = wdata[j*DATA_W + b*8 +: 8];
            if (wclr[j] && (waddr[j*AW +: AW] == ra)) clr_hit = 1'b1;
         end
         for (int k = 0; k < NR_ISSUE; k++)
            if (issue_valid[k] && (issue_dst[k*AW +: AW] == ra)) iss_hit = 1'b1;
         if (clr_hit && !iss_hit) bz = 1'b0;
         if (ra == '0) begin
            rd = '0;
            bz = 1'b0;
         end
      end
`else
      // busy[0] is held at 0, so only the data path needs the reg-0 mask.
      assign rd = (ra == '0) ? '0 : regs[ra];
      assign bz = busy[ra];
`endif

      assign rdata[i*DATA_W +: DATA_W] = rd;
      assign rbusy[i]                  = bz;
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard (default parameters).
// Directed vector table, bypass/no-bypass sequence, randomized traffic against
// an array-based reference model, and an asynchronous mid-cycle reset.
module tb_regfile_scoreboard;

   localparam int RN = 64, DW = 32, NR = 4, NW = 2, NI = 2, AW = 6;

   logic                clk = 1'b0;
   logic                rst;
   logic [NR*AW-1:0]    raddr;
   logic [NR*DW-1:0]    rdata;
   logic [NR-1:0]       rbusy;
   logic [NW*4-1:0]     we;
   logic [NW*AW-1:0]    waddr;
   logic [NW*DW-1:0]    wdata;
   logic [NW-1:0]       wclr;
   logic [NI-1:0]       issue_valid;
   logic [NI*AW-1:0]    issue_dst;
   logic                flush;
   logic [RN-1:0]       busy_vec;

   regfile_scoreboard #(.REG_NUM(RN), .DATA_W(DW), .NR_READ(NR), .NR_WRITE(NW),
                        .NR_ISSUE(NI)) dut (
      .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
      .we(we), .waddr(waddr), .wdata(wdata), .wclr(wclr),
      .issue_valid(issue_valid), .issue_dst(issue_dst), .flush(flush),
      .busy_vec(busy_vec));

   always #5 clk = ~clk;

   // bench-side per-port stimulus, packed onto the DUT buses
   logic [AW-1:0] t_raddr [NR];
   logic [3:0]    t_we    [NW];
   logic [AW-1:0] t_waddr [NW];
   logic [DW-1:0] t_wdata [NW];
   logic          t_wclr  [NW];
   logic          t_iv    [NI];
   logic [AW-1:0] t_idst  [NI];
   logic          t_flush;

   always_comb begin
      raddr = '0; we = '0; waddr = '0; wdata = '0; wclr = '0;
      issue_valid = '0; issue_dst = '0;
      for (int i = 0; i < NR; i++) raddr[i*AW +: AW] = t_raddr[i];
      for (int j = 0; j < NW; j++) begin
         we[j*4 +: 4]      = t_we[j];
         waddr[j*AW +: AW] = t_waddr[j];
         wdata[j*DW +: DW] = t_wdata[j];
         wclr[j]           = t_wclr[j];
      end
      for (int k = 0; k < NI; k++) begin
         issue_valid[k]        = t_iv[k];
         issue_dst[k*AW +: AW] = t_idst[k];
      end
      flush = t_flush;
   end

   // reference model: plain register and busy arrays
   logic [DW-1:0] m_reg  [RN];
   logic          m_busy [RN];

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < RN; r++) begin
         m_reg[r]  = '0;
         m_busy[r] = 1'b0;
      end
   endtask

   task automatic idle();
      for (int i = 0; i < NR; i++) t_raddr[i] = '0;
      for (int j = 0; j < NW; j++) begin
         t_we[j] = '0; t_waddr[j] = '0; t_wdata[j] = '0; t_wclr[j] = 1'b0;
      end
      for (int k = 0; k < NI; k++) begin
         t_iv[k] = 1'b0; t_idst[k] = '0;
      end
      t_flush = 1'b0;
   endtask

   function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
      logic [DW-1:0] v;
      if (a == 0) return '0;
      v = m_reg[a];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NW; j++)
         for (int b = 0; b < 4; b++)
            if (t_we[j][b] && t_waddr[j] == a) v[b*8 +: 8] = t_wdata[j][b*8 +: 8];
`endif
      return v;
   endfunction

   function automatic logic exp_rbusy(input logic [AW-1:0] a);
      logic cl, is;
      if (a == 0) return 1'b0;
      cl = 1'b0; is = 1'b0;
      for (int j = 0; j < NW; j++) if (t_wclr[j] && t_waddr[j] == a) cl = 1'b1;
      for (int k = 0; k < NI; k++) if (t_iv[k] && t_idst[k] == a) is = 1'b1;
`ifdef REGFILE_BYPASS_EN
      if (cl && !is) return 1'b0;
`endif
      return m_busy[a];
   endfunction

   function automatic logic [RN-1:0] model_bvec();
      logic [RN-1:0] v;
      for (int r = 0; r < RN; r++) v[r] = m_busy[r];
      return v;
   endfunction

   // one clock step: effect of this cycle's inputs per the register-file rules
   task automatic model_edge();
      logic set, clr;
      for (int j = 0; j < NW; j++)
         for (int b = 0; b < 4; b++)
            if (t_we[j][b] && t_waddr[j] != 0) m_reg[t_waddr[j]][b*8 +: 8] = t_wdata[j][b*8 +: 8];
      for (int r = 1; r < RN; r++) begin
         set = 1'b0; clr = 1'b0;
         for (int k = 0; k < NI; k++) if (t_iv[k] && t_idst[k] == r) set = 1'b1;
         for (int j = 0; j < NW; j++) if (t_wclr[j] && t_waddr[j] == r) clr = 1'b1;
         if (t_flush)  m_busy[r] = 1'b0;
         else if (set) m_busy[r] = 1'b1;
         else if (clr) m_busy[r] = 1'b0;
      end
   endtask

   // Called at a negedge with inputs set; checks read ports before the edge
   // and the scoreboard after it, returns at the next negedge.
   task automatic cycle();
      #1;
      for (int i = 0; i < NR; i++) begin
         chk($sformatf("rdata[%0d] a=%0d", i, t_raddr[i]), 64'(rdata[i*DW +: DW]), 64'(exp_rdata(t_raddr[i])));
         chk($sformatf("rbusy[%0d] a=%0d", i, t_raddr[i]), 64'(rbusy[i]), 64'(exp_rbusy(t_raddr[i])));
      end
      @(posedge clk);
      model_edge();
      #1;
      chk("busy_vec", busy_vec, model_bvec());
      @(negedge clk);
   endtask

   typedef struct {
      logic [3:0] we0; logic [5:0] wa0; logic [31:0] wd0;
      logic [3:0] we1; logic [5:0] wa1; logic [31:0] wd1;
      logic [1:0] clr; logic [1:0] iv; logic [5:0] d0; logic [5:0] d1;
      logic       fl;  logic [5:0] ca; logic [31:0] ed; logic eb;
   } vec_t;

   vec_t tv [12];

   initial begin
      tv[0]  = '{4'hF, 6'd7, 32'h11223344, 4'h0, 6'd0, 32'h0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 6'd7,  32'h11223344, 1'b0};
      tv[1]  = '{4'h3, 6'd7, 32'hAAAAAAAA, 4'h6, 6'd7, 32'hBBBBBBBB, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 6'd7, 32'h11BBBBAA, 1'b0};
      tv[2]  = '{4'hF, 6'd0, 32'hFFFFFFFF, 4'h0, 6'd0, 32'h0, 2'b00, 2'b01, 6'd0, 6'd0, 1'b0, 6'd0,  32'h0, 1'b0};
      tv[3]  = '{4'h0, 6'd0, 32'h0, 4'h0, 6'd0, 32'h0, 2'b00, 2'b01, 6'd9,  6'd0, 1'b0, 6'd9,  32'h0, 1'b1};
      tv[4]  = '{4'h0, 6'd0, 32'h0, 4'h0, 6'd0, 32'h0, 2'b00, 2'b00, 6'd0,  6'd0, 1'b0, 6'd9,  32'h0, 1'b1};
      tv[5]  = '{4'h0, 6'd9, 32'h0, 4'h0, 6'd0, 32'h0, 2'b01, 2'b00, 6'd0,  6'd0, 1'b0, 6'd9,  32'h0, 1'b0};
      tv[6]  = '{4'h0, 6'd0, 32'h0, 4'h0, 6'd9, 32'h0, 2'b10, 2'b01, 6'd9,  6'd0, 1'b0, 6'd9,  32'h0, 1'b1};
      tv[7]  = '{4'h0, 6'd0, 32'h0, 4'h0, 6'd0, 32'h0, 2'b00, 2'b11, 6'd3,  6'd4, 1'b0, 6'd3,  32'h0, 1'b1};
      tv[8]  = '{4'h0, 6'd0, 32'h0, 4'h0, 6'd0, 32'h0, 2'b00, 2'b01, 6'd12, 6'd0, 1'b0, 6'd12, 32'h0, 1'b1};
      tv[9]  = '{4'h0, 6'd0, 32'h0, 4'h0, 6'd0, 32'h0, 2'b00, 2'b01, 6'd20, 6'd0, 1'b1, 6'd20, 32'h0, 1'b0};
      tv[10] = '{4'h0, 6'd0, 32'h0, 4'h0, 6'd0, 32'h0, 2'b00, 2'b00, 6'd0,  6'd0, 1'b0, 6'd3,  32'h0, 1'b0};
      tv[11] = '{4'h0, 6'd0, 32'h0, 4'h0, 6'd0, 32'h0, 2'b00, 2'b11, 6'd5,  6'd5, 1'b0, 6'd5,  32'h0, 1'b1};

      idle();
      model_reset();
      rst = 1'b1;
      @(negedge clk);
      chk("reset busy_vec", busy_vec, 64'h0);
      t_raddr[0] = 6'd7;
      #1 chk("reset rdata", 64'(rdata[DW-1:0]), 64'h0);
      @(negedge clk);
      rst = 1'b0;

      // directed vector table: apply op for one cycle, then read back
      for (int v = 0; v < 12; v++) begin
         idle();
         t_we[0] = tv[v].we0; t_waddr[0] = tv[v].wa0; t_wdata[0] = tv[v].wd0;
         t_we[1] = tv[v].we1; t_waddr[1] = tv[v].wa1; t_wdata[1] = tv[v].wd1;
         t_wclr[0] = tv[v].clr[0]; t_wclr[1] = tv[v].clr[1];
         t_iv[0] = tv[v].iv[0]; t_iv[1] = tv[v].iv[1];
         t_idst[0] = tv[v].d0; t_idst[1] = tv[v].d1;
         t_flush = tv[v].fl;
         cycle();
         idle();
         t_raddr[0] = tv[v].ca;
         #1;
         chk($sformatf("vec%0d data", v), 64'(rdata[DW-1:0]), 64'(tv[v].ed));
         chk($sformatf("vec%0d busy", v), 64'(rbusy[0]), 64'(tv[v].eb));
         if (v == 9) chk("flush busy_vec", busy_vec, 64'h0);
      end

      // same-cycle writeback read of a busy register
      @(negedge clk);
      idle();
      t_we[0] = 4'hF; t_waddr[0] = 6'd6; t_wdata[0] = 32'hCAFEF00D;
      t_iv[0] = 1'b1; t_idst[0] = 6'd6;
      cycle();
      idle();
      t_we[0] = 4'hF; t_waddr[0] = 6'd6; t_wdata[0] = 32'h12345678; t_wclr[0] = 1'b1;
      t_raddr[0] = 6'd6;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("bypass data", 64'(rdata[DW-1:0]), 64'h12345678);
      chk("bypass busy", 64'(rbusy[0]), 64'h0);
`else
      chk("nobypass data", 64'(rdata[DW-1:0]), 64'hCAFEF00D);
      chk("nobypass busy", 64'(rbusy[0]), 64'h1);
`endif
      cycle();

      // randomized traffic, addresses folded into 0..15 for frequent collisions
      for (int c = 0; c < 400; c++) begin
         idle();
         for (int i = 0; i < NR; i++) t_raddr[i] = 6'($urandom_range(0, 15));
         for (int j = 0; j < NW; j++) begin
            t_we[j]    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            t_waddr[j] = 6'($urandom_range(0, 15));
            t_wdata[j] = $urandom;
            t_wclr[j]  = 1'($urandom);
         end
         for (int k = 0; k < NI; k++) begin
            t_iv[k]   = 1'($urandom);
            t_idst[k] = 6'($urandom_range(0, 15));
         end
         t_flush = ($urandom_range(0, 15) == 0);
         cycle();
      end

      // asynchronous reset between edges
      idle();
      t_we[0] = 4'hF; t_waddr[0] = 6'd5; t_wdata[0] = 32'hDEADBEEF;
      t_iv[0] = 1'b1; t_idst[0] = 6'd5;
      cycle();
      idle();
      t_raddr[0] = 6'd5;
      #1 chk("pre-reset data", 64'(rdata[DW-1:0]), 64'hDEADBEEF);
      #1 rst = 1'b1;
      #1;
      chk("async reset data", 64'(rdata[DW-1:0]), 64'h0);
      chk("async reset busy_vec", busy_vec, 64'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised multi-port integer register file with per-byte write enables, for the issue stage of the dual-issue core.
- Adds a per-register busy scoreboard. Issue marks a destination busy; writeback clears it.
- Adds flush of all pending busy bits and an optional same-cycle write-to-read bypass.
- Successor to the fixed 2-write/4-read register file, generalised in port count, depth and width.

Parameters:
- REG_NUM, 64, number of architectural registers; register 0 is hardwired zero.
- DATA_W, 32, register width in bits; must be a multiple of 8.
- NR_READ, 4, number of read ports.
- NR_WRITE, 2, number of write/writeback ports.
- NR_ISSUE, 2, number of issue (busy-set) ports.
- AW, $clog2(REG_NUM), address width (derived).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- raddr  in  NR_READ*AW  read addresses, port i at [i*AW +: AW].
- rdata  out  NR_READ*DATA_W  read data, combinational.
- rbusy  out  NR_READ  busy bit of the register at raddr[i], combinational.
- we  in  NR_WRITE*(DATA_W/8)  per-byte write enables per write port.
- waddr  in  NR_WRITE*AW  write addresses.
- wdata  in  NR_WRITE*DATA_W  write data.
- wclr  in  NR_WRITE  writeback completes the producer; clears the busy bit of waddr[j].
- issue_valid  in  NR_ISSUE  issue port k allocates a destination.
- issue_dst  in  NR_ISSUE*AW  destination register per issue port.
- flush  in  1  clear all busy bits (pipeline flush).
- busy_vec  out  REG_NUM  full scoreboard, registered.

Behaviour:
- Reset (async, rst=1): all registers = 0; all busy bits = 0; busy_vec = 0. rdata and rbusy follow from the cleared state.
- Reset mid-operation: state clears immediately, regardless of clk.
- Read, reg 0: raddr==0 gives rdata=0 and rbusy=0 always.
- Read, other registers: rdata = stored value; rbusy = busy[raddr].
- Read latency: 0 cycles (combinational).
- Write: at posedge, for each port j and byte b with we[j][b]=1 and waddr[j]!=0, byte b of reg[waddr[j]] takes wdata[j] byte b. Bytes with we=0 are unchanged.
- Write conflict (same address, same byte, multiple ports): the highest-index port wins. Non-overlapping bytes from different ports to the same register all commit in the same cycle.
- Writes to reg 0 are discarded.
- Busy update at posedge, applied in priority order:
  1. flush=1: all busy bits cleared; issue_valid ignored this cycle; wclr irrelevant.
  2. Otherwise, per register r:
     - set if any issue_valid[k] with issue_dst[k]==r;
     - else cleared if any wclr[j] with waddr[j]==r;
     - else unchanged.
  3. Simultaneous set and clear of the same register: set wins (a new producer supersedes the old one).
  4. Issue to reg 0 is ignored; busy[0] is constantly 0.
- wclr does not require we≠0. A clear with we=0 updates the scoreboard only.
- Two issue ports naming the same destination: single set, no error.
- busy_vec is the registered scoreboard, with no bypass of same-cycle set/clear.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - rdata[i] forwards same-cycle write data byte-wise. For each byte, use the highest-index port with we set and waddr==raddr[i] (raddr!=0); otherwise use the stored byte.
  - rbusy[i] is forced 0 when a same-cycle wclr targets raddr[i] and no same-cycle issue targets it, so an issue-stage consumer can read and proceed in the writeback cycle.
- Undefined: rdata and rbusy reflect stored state only; written values are visible one cycle after the write edge.

Test Plan:
- Reset: write reg5=0xDEADBEEF, then assert rst between edges -> rdata(raddr=5)=0 immediately and busy_vec=0.
- Byte merge: reg7=0x11223344; port0 we=0011 wdata=0xAAAAAAAA and port1 we=0110 wdata=0xBBBBBBBB, both to reg7 -> next cycle reg7=0x11BBBBAA (port1 wins byte1).
- Reg 0: write 0xFFFFFFFF with we=1111 to reg0 and issue dst=0 -> rdata=0, rbusy=0, busy_vec[0]=0.
- Scoreboard: issue dst=9 at cycle N -> busy_vec[9]=1 at N+1; wclr to 9 at N+3 -> busy_vec[9]=0 at N+4. Issue dst=9 with simultaneous wclr 9 -> stays 1.
- Flush: busy regs 3,4,12; flush=1 together with issue dst=20 -> next cycle busy_vec=0, reg20 not busy.
- Bypass (REGFILE_BYPASS_EN), busy reg 6 with wclr, we=1111, wdata=0x12345678 to reg6 and raddr=6 in the same cycle -> rdata=0x12345678, rbusy=0. Without the macro -> old value, rbusy=1.
